// File: rtl/point_mul_io.sv
// Word-stream front end for an elliptic-curve point multiplier.
// Loads scalar k and base point (Px, Py) as WW-bit words, pulses the
// downstream multiplier, times it, then streams the result (Qx, Qy) out.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_data    : operand words, k then Px then Py, LS first
//   out_valid/out_ready/out_data : result words, Qx then Qy, LS first
//   busy   : high outside LOAD
//   cycles : WAIT cycles of the last multiply, saturating
//   pm_start, pm_k, pm_px, pm_py : drive the multiplier
//   pm_qx, pm_qy, pm_finish      : multiplier result and done level
module point_mul_io #(
    parameter int DW = 257,
    parameter int WW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WW-1:0] out_data,
    output logic          busy,
    output logic [31:0]   cycles,
    output logic          pm_start,
    output logic [DW-1:0] pm_k,
    output logic [DW-1:0] pm_px,
    output logic [DW-1:0] pm_py,
    input  logic [DW-1:0] pm_qx,
    input  logic [DW-1:0] pm_qy,
    input  logic          pm_finish
);

    localparam int NW = (DW + WW - 1) / WW;
    localparam int CW = $clog2(3 * NW);
    localparam int PB = $clog2(DW);

    localparam logic [CW-1:0] NW1      = CW'(NW);
    localparam logic [CW-1:0] NW2      = CW'(2 * NW);
    localparam logic [CW-1:0] LAST_IN  = CW'(3 * NW - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(2 * NW - 1);

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        UNLOAD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [DW-1:0]   k_q, k_d;
    logic [DW-1:0]   px_q, px_d;
    logic [DW-1:0]   py_q, py_d;
    logic [DW-1:0]   qx_q, qx_d;
    logic [DW-1:0]   qy_q, qy_d;
    logic [31:0]     cyc_q, cyc_d;

    logic [1:0]      in_sel;
    logic [CW-1:0]   in_idx;
    logic [CW-1:0]   out_idx;

    // Bits of a word that fall above DW-1 (top word) are dropped.
    function automatic logic [DW-1:0] put_word(
        input logic [DW-1:0] v,
        input logic [CW-1:0] i,
        input logic [WW-1:0] w
    );
        int p;
        for (int b = 0; b < WW; b++) begin
            p = WW * int'(i) + b;
            if (p < DW) v[PB'(p)] = w[b];
        end
        return v;
    endfunction

    // Bits above DW-1 read back as zero.
    function automatic logic [WW-1:0] get_word(
        input logic [DW-1:0] v,
        input logic [CW-1:0] i
    );
        logic [WW-1:0] w;
        int p;
        w = '0;
        for (int b = 0; b < WW; b++) begin
            p = WW * int'(i) + b;
            if (p < DW) w[b] = v[PB'(p)];
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LOAD;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            k_q       <= '0;
            px_q      <= '0;
            py_q      <= '0;
            qx_q      <= '0;
            qy_q      <= '0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            k_q       <= k_d;
            px_q      <= px_d;
            py_q      <= py_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            cyc_q     <= cyc_d;
        end
    end

    // Split the flat 0..3*NW-1 load count into operand and word index.
    always_comb begin
        in_sel = 2'd0;
        in_idx = in_cnt_q;
        if (in_cnt_q >= NW2) begin
            in_sel = 2'd2;
            in_idx = in_cnt_q - NW2;
        end else if (in_cnt_q >= NW1) begin
            in_sel = 2'd1;
            in_idx = in_cnt_q - NW1;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        k_d       = k_q;
        px_d      = px_q;
        py_d      = py_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        cyc_d     = cyc_q;
        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    case (in_sel)
                        2'd0:    k_d  = put_word(k_q, in_idx, in_data);
                        2'd1:    px_d = put_word(px_q, in_idx, in_data);
                        default: py_d = put_word(py_q, in_idx, in_data);
                    endcase
                    if (in_cnt_q == LAST_IN) begin
                        in_cnt_d = '0;
                        state_d  = START;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            START: begin
                cyc_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (pm_finish) begin
                    qx_d    = pm_qx;
                    qy_d    = pm_qy;
                    state_d = UNLOAD;
                end else if (cyc_q != '1) begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (out_cnt_q == LAST_OUT) begin
                        out_cnt_d = '0;
                        state_d   = LOAD;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        out_idx  = out_cnt_q;
        out_data = '0;
        if (state_q == UNLOAD) begin
            if (out_cnt_q < NW1) begin
                out_data = get_word(qx_q, out_idx);
            end else begin
                out_idx  = out_cnt_q - NW1;
                out_data = get_word(qy_q, out_idx);
            end
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == UNLOAD);
    assign busy      = (state_q != LOAD);
    assign pm_start  = (state_q == START);
    assign cycles    = cyc_q;
    assign pm_k      = k_q;
    assign pm_px     = px_q;
    assign pm_py     = py_q;

endmodule

// File: tb/tb_point_mul_io.sv
// Directed-plus-random bench for point_mul_io with a stub multiplier.
// Expected operands/results come from word arithmetic on the stimulus.
module tb_point_mul_io;

    localparam int DW = 257;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic          busy;
    logic [31:0]   cycles;
    logic          pm_start;
    logic [DW-1:0] pm_k, pm_px, pm_py;
    logic [DW-1:0] pm_qx = '0;
    logic [DW-1:0] pm_qy = '0;
    logic          pm_finish = 1'b0;

    int total = 0;
    int passed = 0;

    int dly = 10;
    int scnt = 0;
    bit srun = 1'b0;

    logic [31:0]   words[27];
    logic [31:0]   expw[18];
    logic [DW-1:0] ek, epx, epy;

    always #5 clk = ~clk;

    point_mul_io #(.DW(DW), .WW(WW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .cycles(cycles),
        .pm_start(pm_start), .pm_k(pm_k), .pm_px(pm_px), .pm_py(pm_py),
        .pm_qx(pm_qx), .pm_qy(pm_qy), .pm_finish(pm_finish)
    );

    // Stub multiplier: finish rises after dly cycles following the start.
    always @(posedge clk) begin
        if (pm_start) begin
            scnt      <= 0;
            pm_finish <= 1'b0;
            srun      <= 1'b1;
        end else if (srun) begin
            scnt <= scnt + 1;
            if (scnt + 1 == dly) begin
                pm_finish <= 1'b1;
                srun      <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] assemble(input int off);
        logic [287:0] acc;
        acc = '0;
        for (int i = 0; i < 9; i++)
            acc = acc | (288'(words[off+i]) << (32 * i));
        return acc[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_val();
        logic [287:0] t;
        t = '0;
        for (int i = 0; i < 9; i++) t = {t[255:0], 32'($urandom)};
        return t[DW-1:0];
    endfunction

    task automatic set_result(input logic [DW-1:0] qx,
                              input logic [DW-1:0] qy, input int d);
        pm_qx = qx;
        pm_qy = qy;
        dly   = d;
        for (int i = 0; i < 9; i++) begin
            expw[i]   = 32'(qx >> (32 * i));
            expw[i+9] = 32'(qy >> (32 * i));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, DW'(in_ready), DW'(1));
        chk({tag, "_out_valid"}, DW'(out_valid), DW'(0));
        chk({tag, "_out_data"}, DW'(out_data), DW'(0));
        chk({tag, "_busy"}, DW'(busy), DW'(0));
        chk({tag, "_pm_start"}, DW'(pm_start), DW'(0));
        chk({tag, "_cycles"}, DW'(cycles), DW'(0));
        chk({tag, "_pm_k"}, pm_k, DW'(0));
        chk({tag, "_pm_px"}, pm_px, DW'(0));
        chk({tag, "_pm_py"}, pm_py, DW'(0));
    endtask

    // Drives all 27 words, then keeps in_valid high with junk data.
    task automatic load_run();
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            chk("load_in_ready", DW'(in_ready), DW'(1));
            in_valid = 1'b1;
            in_data  = words[i];
        end
        @(negedge clk);
        in_data = $urandom;
        chk("start_pulse", DW'(pm_start), DW'(1));
        chk("start_in_ready", DW'(in_ready), DW'(0));
        chk("start_busy", DW'(busy), DW'(1));
        chk("pm_k", pm_k, ek);
        chk("pm_px", pm_px, epx);
        chk("pm_py", pm_py, epy);
        @(negedge clk);
        in_data = $urandom;
        chk("start_one_cycle", DW'(pm_start), DW'(0));
        chk("cycles_cleared", DW'(cycles), DW'(0));
    endtask

    task automatic wait_unload(input int d);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            in_data = $urandom;
            n++;
        end
        chk("unload_reached", DW'(out_valid), DW'(1));
        chk("cycles", DW'(cycles), DW'(d));
        chk("illegal_in_ready", DW'(in_ready), DW'(0));
        chk("hold_pm_k", pm_k, ek);
        chk("hold_pm_px", pm_px, epx);
        chk("hold_pm_py", pm_py, epy);
    endtask

    // mode 0: out_ready toggles every other cycle; mode 1: random.
    task automatic collect(input int mode);
        int got, guard;
        bit stalled, r;
        logic [31:0] prevd;
        got = 0;
        guard = 0;
        stalled = 1'b0;
        prevd = '0;
        while (got < 18 && guard < 400) begin
            if (stalled) chk("stall_stable", DW'(out_data), DW'(prevd));
            r = (mode == 0) ? guard[0] : 1'($urandom);
            if (r && out_valid) begin
                chk($sformatf("word%0d", got), DW'(out_data), DW'(expw[got]));
                got++;
                if (got == 18) in_valid = 1'b0;
            end
            stalled   = out_valid && !r;
            prevd     = out_data;
            out_ready = r;
            guard++;
            @(negedge clk);
            if (got < 18) in_data = $urandom;
        end
        out_ready = 1'b0;
        chk("word_count", DW'(got), DW'(18));
        chk("post_in_ready", DW'(in_ready), DW'(1));
        chk("post_out_valid", DW'(out_valid), DW'(0));
        chk("post_out_data", DW'(out_data), DW'(0));
        chk("post_busy", DW'(busy), DW'(0));
    endtask

    task automatic rand_words();
        for (int i = 0; i < 27; i++) words[i] = $urandom;
        ek  = assemble(0);
        epx = assemble(9);
        epy = assemble(18);
    endtask

    initial begin
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;

        // Run 1: fixed operands, fixed result, toggling backpressure.
        for (int i = 0; i < 27; i++) words[i] = '0;
        words[0]  = 32'h0000_0001;
        words[17] = 32'hFFFF_FFFF;
        ek  = DW'(1);
        epx = DW'(1) << 256;
        epy = '0;
        set_result('1, '0, 10);
        load_run();
        wait_unload(10);
        collect(0);

        // Run 2: back-to-back with random operands and result.
        rand_words();
        set_result(rand_val(), rand_val(), 3 + int'($urandom_range(0, 17)));
        load_run();
        wait_unload(dly);
        collect(1);

        // Reset mid-LOAD, then a full load must start at k word 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_vals("rst_load");
        @(negedge clk);
        rst = 1'b1;
        rand_words();
        set_result(rand_val(), rand_val(), 1 + int'($urandom_range(0, 7)));
        load_run();
        wait_unload(dly);

        // Reset mid-UNLOAD after a few words have gone out.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_vals("rst_unload");
        @(negedge clk);
        rst = 1'b1;
        rand_words();
        set_result(rand_val(), rand_val(), 12);
        load_run();
        wait_unload(12);
        collect(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/point_mul_io.md
POINT_MUL_IO -- requirements
Module: point_mul_io

Interface
REQ-001 SHALL have parameter DW, default 257, field element / scalar width in bits.
REQ-002 SHALL have parameter WW, default 32, stream word width; NW = ceil(DW/WW) = 9 words per operand.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input word valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input word.
REQ-007 SHALL have port in_data  input  WW  input word.
REQ-008 SHALL have port out_valid  output  1  output word valid.
REQ-009 SHALL have port out_ready  input  1  sink accepts output word.
REQ-010 SHALL have port out_data  output  WW  output word.
REQ-011 SHALL have port busy  output  1  high in any state other than LOAD.
REQ-012 SHALL have port cycles  output  32  point-multiply latency of the last run.
REQ-013 SHALL have port pm_start  output  1  start pulse to downstream point multiplier.
REQ-014 SHALL have ports pm_k, pm_px, pm_py  output  DW each  scalar and base point driven to the multiplier.
REQ-015 SHALL have ports pm_qx, pm_qy  input  DW each  result point from the multiplier.
REQ-016 SHALL have port pm_finish  input  1  multiplier done flag (level, low while its start is high).

Function
REQ-017 SHALL implement states LOAD, START, WAIT, UNLOAD; LOAD is the reset state.
REQ-018 in_ready SHALL be 1 exactly in LOAD; handshake = in_valid & in_ready on a rising edge.
REQ-019 LOAD SHALL accept 27 words in order: k words 0..8, Px words 0..8, Py words 0..8, least-significant word first; word i of an operand maps to bits [WW*i +: WW].
REQ-020 For word 8 of each operand only bit 0 SHALL be stored (operand bit 256); bits 31:1 SHALL be discarded.
REQ-021 A 5-bit word counter SHALL count handshakes 0..26; on the 27th handshake it SHALL wrap to 0 and the state SHALL move to START.
REQ-022 In START pm_start SHALL be 1 for exactly one cycle, cycles SHALL be cleared to 0, then state SHALL move to WAIT.
REQ-023 pm_k, pm_px, pm_py SHALL be registered and SHALL be stable from START until the next LOAD handshake that writes them.
REQ-024 In WAIT, pm_finish SHALL be ignored on the first WAIT cycle is not required; pm_finish SHALL be sampled every WAIT cycle.
REQ-025 Each WAIT cycle with pm_finish=0 SHALL increment cycles by 1, saturating at 0xFFFFFFFF.
REQ-026 A WAIT cycle with pm_finish=1 SHALL capture pm_qx, pm_qy into an internal output buffer and move to UNLOAD; cycles SHALL then hold until the next START.
REQ-027 UNLOAD SHALL emit 18 words: Qx words 0..8 then Qy words 0..8, LS word first; word 8 SHALL carry bit 256 in bit 0 with bits 31:1 zero.
REQ-028 out_valid SHALL be 1 exactly in UNLOAD, from the first UNLOAD cycle.
REQ-029 While out_valid=1 and out_ready=0, out_data SHALL hold stable; a word SHALL advance only on out_valid & out_ready.
REQ-030 After the 18th output handshake the state SHALL return to LOAD; in_ready SHALL be 1 in the following cycle.
REQ-031 in_valid outside LOAD SHALL be ignored with no register change; out_ready outside UNLOAD SHALL be ignored.
REQ-032 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-033 rst=0 SHALL immediately force state LOAD, word counters 0, in_ready 1, out_valid 0, out_data 0, busy 0, pm_start 0, cycles 0, pm_k/pm_px/pm_py 0, output buffer 0.
REQ-034 rst asserted in any state (including mid-LOAD or mid-UNLOAD) SHALL discard partial words; the next load SHALL start at k word 0.

Verification
REQ-035 Reset: assert rst=0 mid-run -> all outputs at REQ-033 values in the same cycle, in_ready=1 after release.
REQ-036 Load: k word0=0x00000001, Px word8=0xFFFFFFFF, rest 0 -> pm_k=1, pm_px=1<<256, pm_py=0; pm_start high exactly one cycle, in the cycle after the 27th handshake.
REQ-037 Result: stub raises pm_finish after 10 WAIT cycles with pm_qx=all-ones(257), pm_qy=0 -> cycles=10; outputs 8x 0xFFFFFFFF, 0x00000001, then 9x 0x00000000.
REQ-038 Backpressure: out_ready toggled every other cycle -> out_data stable while stalled, exactly 18 words, none lost or duplicated.
REQ-039 Illegal input: in_valid=1 held through START/WAIT/UNLOAD -> in_ready=0, pm_k/pm_px/pm_py unchanged.
REQ-040 Back-to-back: two full runs with different operands -> second run's outputs match second stub result, cycles reflects second run only.
